pc_status_unit: RTL

- Downstream consumer of the main decoder's control outputs (branch, blezalsig, balvsig, brvsig, jalpcsig, jmxorsig, status_write_sig) in the single-cycle datapath.
- Owns the program counter and the 3-bit status register {Z,N,V}, and computes the next PC for sequential, beq, blezal, balv, brv, jalpc and jmxor.
- Drives link write-back (pc+4 to $31) and runs a 2-cycle memory-indirect sequence for jmxor.

---
 rtl/pc_status_if.sv | 47 ++++
 rtl/pc_status_unit.sv | 117 +++++++++++
 2 files changed

// File: rtl/pc_status_if.sv
// Bundle between the main decoder/ALU/data memory and the PC/status unit.
// The master side drives decode strobes and operands; the slave side returns PC, status and link controls.
interface pc_status_if #(
  parameter int WIDTH = 32
);
  logic             en;
  logic             branch;
  logic             blezalsig;
  logic             balvsig;
  logic             brvsig;
  logic             jalpcsig;
  logic             jmxorsig;
  logic             status_write_sig;
  logic             alu_zero;
  logic             alu_neg;
  logic             alu_ovf;
  logic [WIDTH-1:0] imm_sext;
  logic [WIDTH-1:0] rs_value;
  logic [WIDTH-1:0] rt_value;
  logic [WIDTH-1:0] mem_rdata;

  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus4;
  logic [2:0]       status;
  logic             jmx_mem_req;
  logic [WIDTH-1:0] jmx_mem_addr;
  logic             link_we;
  logic [4:0]       link_addr;
  logic [WIDTH-1:0] link_data;
  logic             busy;

  modport master (
    output en, branch, blezalsig, balvsig, brvsig, jalpcsig, jmxorsig,
           status_write_sig, alu_zero, alu_neg, alu_ovf,
           imm_sext, rs_value, rt_value, mem_rdata,
    input  pc, pc_plus4, status, jmx_mem_req, jmx_mem_addr,
           link_we, link_addr, link_data, busy
  );

  modport slave (
    input  en, branch, blezalsig, balvsig, brvsig, jalpcsig, jmxorsig,
           status_write_sig, alu_zero, alu_neg, alu_ovf,
           imm_sext, rs_value, rt_value, mem_rdata,
    output pc, pc_plus4, status, jmx_mem_req, jmx_mem_addr,
           link_we, link_addr, link_data, busy
  );
endinterface

// File: rtl/pc_status_unit.sv
// Program counter, {Z,N,V} status register and next-PC selection for the single-cycle datapath,
// including link write-back and the two-edge memory-indirect jmxor sequence.
module pc_status_unit #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [4:0]       LINK_REG = 5'd31
) (
  input  logic        clk,
  input  logic        reset,
  pc_status_if.slave  bus
);

  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_JMX_WAIT = 1'b1;

  // Word-alignment mask for register/memory-sourced jump targets.
  localparam logic [WIDTH-1:0] ALIGN_MASK = {{(WIDTH-2){1'b1}}, 2'b00};

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [2:0]       status_q, status_d;
  logic [0:0]       state_q, state_d;

  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] imm_shift;
  logic [WIDTH-1:0] rel_target;
  logic [WIDTH-1:0] reg_target;
  logic [WIDTH-1:0] mem_target;
  logic             flag_z, flag_n, flag_v;
  logic             in_run;
  logic             link_we;
  logic             jmx_req;

  assign flag_z = status_q[2];
  assign flag_n = status_q[1];
  assign flag_v = status_q[0];
  assign in_run = (state_q == ST_RUN);

  // The left shift drops the top two immediate bits; all sums wrap modulo 2^WIDTH.
  assign pc_plus4   = pc_q + WIDTH'(4);
  assign imm_shift  = bus.imm_sext << 2;
  assign rel_target = pc_plus4 + imm_shift;
  assign reg_target = bus.rs_value & ALIGN_MASK;
  assign mem_target = bus.mem_rdata & ALIGN_MASK;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    pc_d     = pc_q;
    status_d = status_q;
    state_d  = state_q;
    link_we  = 1'b0;
    jmx_req  = 1'b0;

    case (state_q)
      ST_RUN: begin
        // The memory request follows the decoded jmxor regardless of en; only state changes need en.
        jmx_req = bus.jmxorsig && !bus.brvsig;
        if (bus.en) begin
          if (bus.status_write_sig) begin
            status_d = {bus.alu_zero, bus.alu_neg, bus.alu_ovf};
          end

          if (bus.brvsig) begin
            pc_d = flag_v ? reg_target : pc_plus4;
          end else if (bus.jmxorsig) begin
            state_d = ST_JMX_WAIT;
            link_we = 1'b1;
          end else if (bus.jalpcsig) begin
            pc_d    = rel_target;
            link_we = 1'b1;
          end else if (bus.balvsig) begin
            pc_d    = flag_v ? rel_target : pc_plus4;
            link_we = flag_v;
          end else if (bus.blezalsig) begin
            pc_d    = (flag_z || flag_n) ? rel_target : pc_plus4;
            link_we = flag_z || flag_n;
          end else if (bus.branch) begin
            // beq is the one condition taken from the live ALU flag.
            pc_d = bus.alu_zero ? rel_target : pc_plus4;
          end else begin
            pc_d = pc_plus4;
          end
        end
      end

      default: begin
        if (bus.en) begin
          pc_d    = mem_target;
          state_d = ST_RUN;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      status_q <= 3'b000;
      state_q  <= ST_RUN;
    end else begin
      pc_q     <= pc_d;
      status_q <= status_d;
      state_q  <= state_d;
    end
  end

  assign bus.pc           = pc_q;
  assign bus.pc_plus4     = pc_plus4;
  assign bus.status       = status_q;
  assign bus.jmx_mem_req  = jmx_req;
  assign bus.jmx_mem_addr = bus.rs_value ^ bus.rt_value;
  assign bus.link_we      = link_we;
  assign bus.link_addr    = LINK_REG;
  assign bus.link_data    = pc_plus4;
  assign bus.busy         = !in_run;

endmodule
